// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, line levels and parity helper.
// Build option: TX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

  localparam int unsigned DATA_BITS   = 8;
  localparam logic        IDLE_LEVEL  = 1'b1;
  localparam logic        START_LEVEL = 1'b0;
  localparam logic        STOP_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } uart_state_t;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction

endpackage

// File: rtl/baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each bit with bit_tick.
module baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic bit_tick
);

  localparam int unsigned   CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= bit_tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/transmitter.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, stop bit.
// Build option: define TX_PARITY_EN to insert the parity bit (PARITY_ODD selects odd).
module transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done
);

  uart_state_t          state, state_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [2:0]           bit_idx, bit_idx_n;
  logic                 tx_out_n, busy_n, done_n;
  logic                 accept, bit_tick;

`ifdef TX_PARITY_EN
  logic par, par_n;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  assign accept = (state == IDLE) && tx_start;

  baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .en       (state != IDLE),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      tx_out  <= IDLE_LEVEL;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
`ifdef TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_idx <= bit_idx_n;
      tx_out  <= tx_out_n;
      tx_busy <= busy_n;
      tx_done <= done_n;
`ifdef TX_PARITY_EN
      par     <= par_n;
`endif
    end
  end

  // Outputs are computed for the upcoming state so the registered line level
  // changes on the same edge as the state itself.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_idx_n = bit_idx;
    tx_out_n  = tx_out;
    done_n    = 1'b0;
`ifdef TX_PARITY_EN
    par_n     = par;
`endif
    unique case (state)
      IDLE: begin
        tx_out_n = IDLE_LEVEL;
        if (tx_start) begin
          state_n   = START;
          shreg_n   = tx_data;
          bit_idx_n = '0;
          tx_out_n  = START_LEVEL;
`ifdef TX_PARITY_EN
          par_n     = calc_parity(tx_data, PARITY_ODD != 0);
`endif
        end
      end
      START: begin
        if (bit_tick) begin
          state_n  = DATA;
          tx_out_n = shreg[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef TX_PARITY_EN
            state_n  = PARITY;
            tx_out_n = par;
`else
            state_n  = STOP;
            tx_out_n = STOP_LEVEL;
`endif
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shreg_n   = shreg >> 1;
            tx_out_n  = shreg[1];
          end
        end
      end
`ifdef TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_n  = STOP;
          tx_out_n = STOP_LEVEL;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          state_n  = IDLE;
          tx_out_n = IDLE_LEVEL;
          done_n   = 1'b1;
        end
      end
      default: begin
        state_n  = IDLE;
        tx_out_n = IDLE_LEVEL;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_transmitter.sv
// Scoreboard bench for transmitter: one instance at 1 clk/bit (even parity) and
// one at 4 clk/bit (odd parity); a per-instance monitor decodes every frame.
module tb_transmitter;

`ifdef TX_PARITY_EN
  localparam int          FL    = 11;
  localparam logic [10:0] FMASK = 11'h7FF;
`else
  localparam int          FL    = 10;
  localparam logic [10:0] FMASK = 11'h3FF;
`endif

  logic       clk = 1'b0;
  logic [1:0] rst, start, rst_q;
  logic [7:0] data [2];
  logic       out0, busy0, done0, out1, busy1, done1;
  logic [1:0] out_v, busy_v, done_v;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= rst;

  assign out_v  = {out1, out0};
  assign busy_v = {busy1, busy0};
  assign done_v = {done1, done0};

  transmitter #(.CLKS_PER_BIT(1), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .rst(rst[0]), .tx_start(start[0]), .tx_data(data[0]),
    .tx_out(out0), .tx_busy(busy0), .tx_done(done0)
  );

  transmitter #(.CLKS_PER_BIT(4), .PARITY_ODD(1)) u_dut4 (
    .clk(clk), .rst(rst[1]), .tx_start(start[1]), .tx_data(data[1]),
    .tx_out(out1), .tx_busy(busy1), .tx_done(done1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  // Line levels of a whole frame, bit 0 = start bit.
  function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic odd);
`ifdef TX_PARITY_EN
    return {1'b1, (^b) ^ odd, b, 1'b0};
`else
    return {1'b0, 1'b1, b, 1'b0};
`endif
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int   N   = (g == 0) ? 1 : 4;
    localparam logic ODD = (g == 1);
    initial begin : mon
      bit          in_frame;
      bit          post;
      int          cyc;
      logic [10:0] lv;
      logic [7:0]  eb;
      bit          have;
      in_frame = 0;
      post     = 0;
      cyc      = 0;
      lv       = '0;
      forever begin
        @(negedge clk);
        if (rst_q[g]) begin
          check("rst_busy", 32'(busy_v[g]), 0);
          check("rst_out",  32'(out_v[g]),  1);
          check("rst_done", 32'(done_v[g]), 0);
          in_frame = 0;
          post     = 0;
        end else begin
          check("done", 32'(done_v[g]), 32'(post));
          post = 0;
          if (!in_frame && busy_v[g]) begin
            in_frame = 1;
            cyc      = 0;
            lv       = '0;
          end
          if (in_frame) begin
            check("busy", 32'(busy_v[g]), 1);
            if (cyc % N == 0) lv[cyc / N] = out_v[g];
            else check("hold", 32'(out_v[g]), 32'(lv[cyc / N]));
            cyc++;
            if (cyc == FL * N) begin
              in_frame = 0;
              post     = 1;
              have     = 0;
              eb       = '0;
              if (g == 0) begin
                if (q0.size() > 0) begin eb = q0.pop_front(); have = 1; end
              end else begin
                if (q1.size() > 0) begin eb = q1.pop_front(); have = 1; end
              end
              check("sb_nonempty", 32'(have), 1);
              if (have) check("frame", 32'(lv & FMASK), 32'(frame_bits(eb, ODD) & FMASK));
            end
          end else begin
            check("idle_out", 32'(out_v[g]), 1);
          end
        end
      end
    end
  end

  task automatic drive_start(input int g, input logic [7:0] b, input bit expect_frame);
    start[g] = 1'b1;
    data[g]  = b;
    if (expect_frame) begin
      if (g == 0) q0.push_back(b);
      else        q1.push_back(b);
    end
    @(posedge clk);
    #1;
    start[g] = 1'b0;
    data[g]  = 8'($urandom);
  endtask

  task automatic wait_done(input int g, input int limit);
    bit seen;
    seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done_v[g]) seen = 1;
    end
    check("done_timeout", 32'(seen), 1);
  endtask

  task automatic send(input int g, input logic [7:0] b, input int n);
    @(posedge clk);
    #1;
    drive_start(g, b, 1);
    wait_done(g, 16 * n + 8);
  endtask

  initial begin
    rst     = 2'b11;
    start   = 2'b00;
    data[0] = '0;
    data[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 2'b00;

    for (int g = 0; g < 2; g++) begin
      int n;
      n = (g == 0) ? 1 : 4;
      @(negedge clk);
      check("reset_out",  32'(out_v[g]),  1);
      check("reset_busy", 32'(busy_v[g]), 0);
      check("reset_done", 32'(done_v[g]), 0);

      send(g, 8'hA5, n);
      send(g, 8'h07, n);
      send(g, 8'h3C, n);

      // Start pulse and data churn mid-frame must not disturb 0xA5; then a
      // request in the done cycle follows after a single idle cycle.
      @(posedge clk);
      #1;
      drive_start(g, 8'hA5, 1);
      repeat (3 * n) @(posedge clk);
      #1;
      start[g] = 1'b1;
      data[g]  = 8'h55;
      @(posedge clk);
      #1;
      start[g] = 1'b0;
      for (int k = 0; k < 5; k++) begin
        data[g] = 8'($urandom);
        @(posedge clk);
        #1;
      end
      wait_done(g, 16 * n + 8);
      drive_start(g, 8'h55, 1);
      @(negedge clk);
      check("b2b_busy",  32'(busy_v[g]), 1);
      check("b2b_start", 32'(out_v[g]),  0);
      wait_done(g, 16 * n + 8);

      // Reset during data bit 3 aborts the frame without a done pulse.
      @(posedge clk);
      #1;
      drive_start(g, 8'hC3, 0);
      repeat (4 * n) @(posedge clk);
      #1;
      rst[g] = 1'b1;
      @(posedge clk);
      #1;
      rst[g] = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(busy_v[g]), 0);
      check("abort_out",  32'(out_v[g]),  1);
      for (int k = 0; k < 12 * n; k++) begin
        @(negedge clk);
        check("abort_no_done", 32'(done_v[g]), 0);
      end
      send(g, 8'h96, n);

      for (int k = 0; k < 3; k++) send(g, 8'($urandom), n);
    end

    repeat (4) @(negedge clk);
    check("sb_empty0", 32'(q0.size()), 0);
    check("sb_empty1", 32'(q1.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
